// File: rtl/sprite_move_scheduler.sv
// Sprite position owner for the VGA renderer: round-robin move arbitration into a
// shadow position file, committed once per frame at vertical-blank start.
module sprite_move_scheduler #(
  parameter int SIZE     = 16,
  parameter int STEP     = 2,
  parameter int V_ACTIVE = 480,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 624,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 464,
  parameter int P_X0     = 304,
  parameter int P_Y0     = 352,
  parameter int G1_X0    = 304,
  parameter int G1_Y0    = 160,
  parameter int G2_X0    = 272,
  parameter int G2_Y0    = 208,
  parameter int G3_X0    = 336,
  parameter int G3_Y0    = 208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [3:0]  req_valid,
  input  logic [7:0]  req_dir,
  output logic [3:0]  req_ready,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [9:0]  ghost_x,
  output logic [9:0]  ghost_y,
  output logic [9:0]  ghost2_x,
  output logic [9:0]  ghost2_y,
  output logic [9:0]  ghost3_x,
  output logic [9:0]  ghost3_y,
  output logic        frame_tick,
  output logic        collision
);

  typedef enum logic {RUN, COMMIT} state_t;

  state_t      state;
  logic [9:0]  sh_x [4];
  logic [9:0]  sh_y [4];
  logic [9:0]  cm_x [4];
  logic [9:0]  cm_y [4];
  logic [1:0]  rr_ptr;
  logic [3:0]  moved;
  logic        cond;
  logic        cond_d;

  logic [3:0]  eligible;
  logic        grant_any;
  logic [1:0]  grant_idx;
  logic [1:0]  dir;
  logic        horiz;
  logic [9:0]  cur;
  logic [10:0] lo;
  logic [10:0] hi;
  logic [10:0] sum;
  logic [9:0]  nxt;
  logic        overlap;

  function automatic logic [9:0] reset_x(input int i);
    case (i)
      0:       return 10'(P_X0);
      1:       return 10'(G1_X0);
      2:       return 10'(G2_X0);
      default: return 10'(G3_X0);
    endcase
  endfunction

  function automatic logic [9:0] reset_y(input int i);
    case (i)
      0:       return 10'(P_Y0);
      1:       return 10'(G1_Y0);
      2:       return 10'(G2_Y0);
      default: return 10'(G3_Y0);
    endcase
  endfunction

  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = (a > b) ? a - b : b - a;
    return d < 10'(SIZE);
  endfunction

  assign cond = (v_cnt == 10'(V_ACTIVE)) && (h_cnt == 11'd0);

  // Rotating priority search starting at rr_ptr; the 2-bit index wraps 3 -> 0 naturally.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eligible  = req_valid & ~moved;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!grant_any && eligible[rr_ptr + 2'(k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_ptr + 2'(k);
      end
    end
    if (state != RUN || rst) grant_any = 1'b0;
    req_ready = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  // Clamped step for the granted sprite; bit 0 of dir selects increment, bit 1 the X axis.
  always_comb begin
    dir   = req_dir[{grant_idx, 1'b0} +: 2];
    horiz = dir[1];
    cur   = horiz ? sh_x[grant_idx] : sh_y[grant_idx];
    lo    = horiz ? 11'(X_MIN) : 11'(Y_MIN);
    hi    = horiz ? 11'(X_MAX) : 11'(Y_MAX);
    sum   = {1'b0, cur} + 11'(STEP);
    if (dir[0]) nxt = (sum > hi) ? hi[9:0] : sum[9:0];
    else        nxt = ({1'b0, cur} < lo + 11'(STEP)) ? lo[9:0] : cur - 10'(STEP);
  end

  always_comb begin
    overlap = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (near(sh_x[0], sh_x[i]) && near(sh_y[0], sh_y[i])) overlap = 1'b1;
    end
  end

  // NOTE: the small shadow and committed files are flops, not RAM, so they reset to home positions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      rr_ptr     <= 2'd0;
      moved      <= 4'd0;
      cond_d     <= 1'b0;
      frame_tick <= 1'b0;
      collision  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_x[i] <= reset_x(i);
        sh_y[i] <= reset_y(i);
        cm_x[i] <= reset_x(i);
        cm_y[i] <= reset_y(i);
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      cond_d     <= cond;
      frame_tick <= cond & ~cond_d;
      case (state)
        RUN: begin
          if (grant_any) begin
            if (horiz) sh_x[grant_idx] <= nxt;
            else       sh_y[grant_idx] <= nxt;
            moved[grant_idx] <= 1'b1;
            rr_ptr           <= grant_idx + 2'd1;
          end
          if (frame_tick) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 4; i++) begin
            cm_x[i] <= sh_x[i];
            cm_y[i] <= sh_y[i];
          end
          collision <= overlap;
          moved     <= 4'd0;
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign player_x = cm_x[0];
  assign player_y = cm_y[0];
  assign ghost_x  = cm_x[1];
  assign ghost_y  = cm_y[1];
  assign ghost2_x = cm_x[2];
  assign ghost2_y = cm_y[2];
  assign ghost3_x = cm_x[3];
  assign ghost3_y = cm_y[3];

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Self-checking bench for sprite_move_scheduler: per-cycle expectations from a
// behavioural model are queued by the stimulus and compared by a negedge monitor.
module tb_sprite_move_scheduler;

  localparam int SIZE  = 16;
  localparam int STEP  = 2;
  localparam int X_MAX = 624;
  localparam int Y_MAX = 464;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [3:0]  req_valid;
  logic [7:0]  req_dir;
  logic [3:0]  req_ready;
  logic [9:0]  player_x, player_y, ghost_x, ghost_y;
  logic [9:0]  ghost2_x, ghost2_y, ghost3_x, ghost3_y;
  logic        frame_tick;
  logic        collision;

  int vectors     = 0;
  int miscompares = 0;
  int ticks_seen  = 0;

  typedef struct packed {
    logic [3:0] ready;
    logic       tick;
    logic       coll;
    logic [9:0] px, py, g1x, g1y, g2x, g2y, g3x, g3y;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: positions as plain integers, one move per requester per frame.
  int   X0[4] = '{304, 304, 272, 336};
  int   Y0[4] = '{352, 160, 208, 208};
  int   sx[4], sy[4], cx[4], cy[4];
  int   m_rr;
  bit [3:0] m_moved;
  bit   m_coll, m_tick, m_cond_d, m_commit;

  logic [3:0] pend;
  logic [1:0] pdir[4];

  sprite_move_scheduler dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
    .player_x(player_x), .player_y(player_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y),
    .ghost2_x(ghost2_x), .ghost2_y(ghost2_y),
    .ghost3_x(ghost3_x), .ghost3_y(ghost3_y),
    .frame_tick(frame_tick), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      sx[i] = X0[i]; sy[i] = Y0[i];
      cx[i] = X0[i]; cy[i] = Y0[i];
    end
    m_rr = 0; m_moved = '0; m_coll = 0; m_tick = 0; m_cond_d = 0; m_commit = 0;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic bit any_hit();
    bit hit = 0;
    for (int i = 1; i < 4; i++) begin
      int dx = sx[0] - sx[i];
      int dy = sy[0] - sy[i];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < SIZE && dy < SIZE) hit = 1;
    end
    return hit;
  endfunction

  // One clock of stimulus: drive inputs, queue the expected outputs, advance the model.
  task automatic step(input bit r, input int v, input int h);
    exp_t e;
    int   g;
    bit   cond;
    @(posedge clk); #1;
    rst = r; v_cnt = 10'(v); h_cnt = 11'(h); req_valid = pend;
    for (int i = 0; i < 4; i++) req_dir[2*i +: 2] = pdir[i];
    if (r) model_reset();
    g = -1;
    if (!r && !m_commit) begin
      for (int k = 0; k < 4; k++) begin
        int idx = (m_rr + k) % 4;
        if (g < 0 && pend[idx] && !m_moved[idx]) g = idx;
      end
    end
    e.ready = (g < 0) ? 4'b0000 : 4'(1 << g);
    e.tick = m_tick; e.coll = m_coll;
    e.px = 10'(cx[0]); e.py = 10'(cy[0]); e.g1x = 10'(cx[1]); e.g1y = 10'(cy[1]);
    e.g2x = 10'(cx[2]); e.g2y = 10'(cy[2]); e.g3x = 10'(cx[3]); e.g3y = 10'(cy[3]);
    exp_q.push_back(e);
    if (!r) begin
      cond = (v == 480 && h == 0);
      if (m_commit) begin
        for (int i = 0; i < 4; i++) begin cx[i] = sx[i]; cy[i] = sy[i]; end
        m_coll = any_hit(); m_moved = '0; m_commit = 0;
      end else begin
        if (g >= 0) begin
          case (pdir[g])
            2'b00:   sy[g] = clamp(sy[g] - STEP, 0, Y_MAX);
            2'b01:   sy[g] = clamp(sy[g] + STEP, 0, Y_MAX);
            2'b10:   sx[g] = clamp(sx[g] - STEP, 0, X_MAX);
            default: sx[g] = clamp(sx[g] + STEP, 0, X_MAX);
          endcase
          m_moved[g] = 1; m_rr = (g + 1) % 4;
          pend[g] = 1'b0;
        end
        m_commit = m_tick;
      end
      m_tick = cond && !m_cond_d;
      m_cond_d = cond;
    end
  endtask

  task automatic set_req(input int i, input int d);
    pend[i] = 1'b1; pdir[i] = 2'(d);
  endtask

  task automatic boundary(input int hold);
    repeat (hold) step(0, 480, 0);
    step(0, 481, 3); step(0, 482, 3); step(0, 483, 3);
  endtask

  task automatic frame_move(input logic [3:0] mask, input int d0, input int d1,
                            input int d2, input int d3);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) if (mask[i]) set_req(i, d[i]);
    for (int n = 0; n < 16 && pend != 4'd0; n++) step(0, 100, 50);
    if (pend != 4'd0) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: pending %b required 0000", pend);
      pend = '0;
    end
    boundary(1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (frame_tick === 1'b1) ticks_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("req_ready", req_ready, e.ready);
      check("frame_tick", frame_tick, e.tick);
      check("collision", collision, e.coll);
      check("player_x", player_x, e.px);
      check("player_y", player_y, e.py);
      check("ghost_x", ghost_x, e.g1x);
      check("ghost_y", ghost_y, e.g1y);
      check("ghost2_x", ghost2_x, e.g2x);
      check("ghost2_y", ghost2_y, e.g2y);
      check("ghost3_x", ghost3_x, e.g3x);
      check("ghost3_y", ghost3_y, e.g3y);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; h_cnt = '0; v_cnt = '0; req_valid = '0; req_dir = '0; pend = '0;
    for (int i = 0; i < 4; i++) pdir[i] = 2'b00;
    model_reset();
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    @(negedge clk);
    check("reset_player_x", player_x, 304);
    check("reset_player_y", player_y, 352);
    check("reset_ready", req_ready, 0);

    // All four request left every cycle: grants 0,1,2,3 then none.
    for (int i = 0; i < 4; i++) set_req(i, 2);
    for (int n = 0; n < 5; n++) begin
      step(0, 100, n + 1);
      @(negedge clk);
      check("rr_order", req_ready, (n < 4) ? (32'd1 << n) : 32'd0);
      pend = 4'hF;
    end
    step(0, 480, 0); step(0, 481, 0); step(0, 482, 0);
    @(negedge clk);
    check("commit_blocks_ready", req_ready, 0);
    pend = '0;
    step(0, 483, 0);
    @(negedge clk);
    check("left_player_x", player_x, 302);
    check("left_ghost_x", ghost_x, 302);
    check("left_ghost2_x", ghost2_x, 270);
    check("left_ghost3_x", ghost3_x, 334);

    // Tear-free: move accepted at line 100 stays hidden until the commit.
    set_req(0, 0);
    step(0, 100, 10); step(0, 200, 0); step(0, 300, 0); step(0, 479, 799);
    @(negedge clk);
    check("tearfree_hold_y", player_y, 352);
    boundary(1);
    @(negedge clk);
    check("tearfree_commit_y", player_y, 350);

    // Handshake on the tick cycle lands in the next commit; held cond gives one tick.
    t0 = ticks_seen;
    step(0, 480, 0);
    set_req(0, 0);
    step(0, 480, 0);
    @(negedge clk);
    check("samecycle_ready", req_ready, 1);
    step(0, 480, 0); step(0, 480, 0);
    @(negedge clk);
    check("samecycle_y", player_y, 348);
    step(0, 481, 0);
    @(negedge clk);
    check("single_tick", ticks_seen - t0, 1);

    // Reset mid-frame with requests pending, then reset during a commit.
    for (int i = 0; i < 4; i++) set_req(i, $urandom_range(3));
    step(0, 100, 0);
    step(1, 150, 7);
    @(negedge clk);
    check("midreset_player_y", player_y, 352);
    check("midreset_ready", req_ready, 0);
    check("midreset_tick", frame_tick, 0);
    step(0, 150, 8);
    step(0, 480, 0); step(0, 481, 0); step(1, 482, 0);
    @(negedge clk);
    check("commitreset_player_x", player_x, 304);
    pend = '0;
    step(0, 10, 0);

    // Clamps: walk the player to the left and bottom edges, then push once more.
    repeat (152) frame_move(4'b0001, 2, 0, 0, 0);
    @(negedge clk);
    check("clamp_left", player_x, 0);
    frame_move(4'b0001, 2, 0, 0, 0);
    @(negedge clk);
    check("clamp_left_hold", player_x, 0);
    repeat (56) frame_move(4'b0001, 1, 0, 0, 0);
    @(negedge clk);
    check("clamp_down", player_y, 464);
    frame_move(4'b0001, 1, 0, 0, 0);
    @(negedge clk);
    check("clamp_down_hold", player_y, 464);

    // Collision: player to (304,200), ghost2 to (290,210), then ghost2 to (288,210).
    step(1, 0, 0); step(0, 0, 0);
    for (int n = 0; n < 76; n++) begin
      if (n < 9)       frame_move(4'b0101, 0, 0, 3, 0);
      else if (n == 9) frame_move(4'b0101, 0, 0, 1, 0);
      else             frame_move(4'b0001, 0, 0, 0, 0);
    end
    @(negedge clk);
    check("coll_player_y", player_y, 200);
    check("coll_ghost2_x", ghost2_x, 290);
    check("coll_ghost2_y", ghost2_y, 210);
    check("coll_set", collision, 1);
    frame_move(4'b0100, 0, 0, 2, 0);
    @(negedge clk);
    check("coll_edge_clear", collision, 0);

    // Randomized traffic with occasional frame boundaries and resets.
    step(1, 0, 0);
    for (int n = 0; n < 500; n++) begin
      bit r;
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(2) == 0) set_req(i, $urandom_range(3));
      r = ($urandom_range(99) == 0);
      if ($urandom_range(14) == 0) begin
        int hold = $urandom_range(4, 1);
        repeat (hold) step(r, 480, 0);
      end else begin
        step(r, $urandom_range(479), $urandom_range(799));
      end
    end
    pend = '0;
    step(0, 0, 0); step(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
